// File: rtl/dcache_flush_unit.sv
// dcache_flush_unit: walks every set of the write-back data cache on a flush
// request, writes back each valid+dirty line one at a time, invalidates the
// set, and acknowledges with a single-cycle pulse once the last set is done.
//
// Handshakes:
//   * meta: meta_req_o/meta_we_o/meta_addr_o are held stable until meta_gnt_i
//     is sampled high; read data returns on meta_*_i the cycle after the grant.
//   * wb: wb_valid_o with wb_set_o/wb_way_o/wb_tag_o is held stable until
//     wb_ready_i is sampled high (transfer on valid && ready); the unit then
//     waits for the wb_done_i pulse before issuing the next request, so at
//     most one writeback is ever outstanding.
module dcache_flush_unit #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 8,
    parameter int TAG_W    = 44,
    parameter int SET_W    = $clog2(NUM_SETS),
    parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    output logic                      flush_ack_o,
    output logic                      busy_o,
    output logic                      meta_req_o,
    output logic                      meta_we_o,
    output logic [SET_W-1:0]          meta_addr_o,
    input  logic                      meta_gnt_i,
    input  logic [NUM_WAYS-1:0]       meta_valid_i,
    input  logic [NUM_WAYS-1:0]       meta_dirty_i,
    input  logic [NUM_WAYS*TAG_W-1:0] meta_tag_i,
    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [SET_W-1:0]          wb_set_o,
    output logic [WAY_W-1:0]          wb_way_o,
    output logic [TAG_W-1:0]          wb_tag_o,
    input  logic                      wb_done_i,
    // Current FSM state for debug/checkers; IDLE encodes as 0.
    output logic [3:0]                state_dbg_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_READ     = 4'd1,
        S_CAPTURE  = 4'd2,
        S_CHECK    = 4'd3,
        S_WB_REQ   = 4'd4,
        S_WB_WAIT  = 4'd5,
        S_INV      = 4'd6,
        S_DONE     = 4'd7,
        S_WAIT_LOW = 4'd8
    } state_e;

    state_e              state, state_nxt;
    logic [SET_W-1:0]    set_cnt;
    logic [NUM_WAYS-1:0] pend;
    logic [TAG_W-1:0]    tags_q [NUM_WAYS];
    logic [WAY_W-1:0]    way_q;
    logic [TAG_W-1:0]    tag_q;
    logic [WAY_W-1:0]    sel_way;
    logic                last_set;

    assign last_set = (set_cnt == SET_W'(NUM_SETS - 1));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (flush_i)    state_nxt = S_READ;
            S_READ:     if (meta_gnt_i) state_nxt = S_CAPTURE;
            S_CAPTURE:                  state_nxt = S_CHECK;
            S_CHECK:    state_nxt = (|pend) ? S_WB_REQ : S_INV;
            S_WB_REQ:   if (wb_ready_i) state_nxt = S_WB_WAIT;
            S_WB_WAIT:  if (wb_done_i)  state_nxt = S_CHECK;
            S_INV:      if (meta_gnt_i) state_nxt = last_set ? S_DONE : S_READ;
            S_DONE:                     state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: if (!flush_i)   state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // Output decode: purely from the registered state.
    always_comb begin
        flush_ack_o = (state == S_DONE);
        busy_o      = (state != S_IDLE) && (state != S_WAIT_LOW);
        meta_req_o  = (state == S_READ) || (state == S_INV);
        meta_we_o   = (state == S_INV);
        wb_valid_o  = (state == S_WB_REQ);
        state_dbg_o = state;
    end

    assign meta_addr_o = set_cnt;
    assign wb_set_o    = set_cnt;
    assign wb_way_o    = way_q;
    assign wb_tag_o    = tag_q;

    // Lowest pending way wins; scanning downwards leaves the smallest index.
    always_comb begin
        sel_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (pend[i]) sel_way = WAY_W'(i);
        end
    end

    // Set counter, pending-writeback mask, captured tags and the latched line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            set_cnt <= '0;
            pend    <= '0;
            way_q   <= '0;
            tag_q   <= '0;
            for (int w = 0; w < NUM_WAYS; w++) tags_q[w] <= '0;
        end else begin
            case (state)
                S_IDLE: if (flush_i) set_cnt <= '0;
                S_CAPTURE: begin
                    pend <= meta_valid_i & meta_dirty_i;
                    for (int w = 0; w < NUM_WAYS; w++) tags_q[w] <= meta_tag_i[w*TAG_W +: TAG_W];
                end
                S_CHECK: begin
                    if (|pend) begin
                        pend  <= pend & ~(NUM_WAYS'(1) << sel_way);
                        way_q <= sel_way;
                        tag_q <= tags_q[sel_way];
                    end
                end
                S_INV: if (meta_gnt_i && !last_set) set_cnt <= set_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Bench for dcache_flush_unit: a behavioural metadata array and writeback
// responder drive the DUT; expected per-set operation order, writeback lines
// and acknowledge cycle are derived from the array contents and the cycle
// costs chosen by the bench.
module tb_dcache_flush_unit;

    localparam int NS  = 4;
    localparam int NW  = 2;
    localparam int TW  = 12;
    localparam int SW  = 2;
    localparam int WW  = 1;
    localparam int EW  = SW + WW + TW;
    localparam int MTW = NW * TW;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           flush_i;
    logic           flush_ack_o;
    logic           busy_o;
    logic           meta_req_o;
    logic           meta_we_o;
    logic [SW-1:0]  meta_addr_o;
    logic           meta_gnt_i;
    logic [NW-1:0]  meta_valid_i;
    logic [NW-1:0]  meta_dirty_i;
    logic [MTW-1:0] meta_tag_i;
    logic           wb_valid_o;
    logic           wb_ready_i;
    logic [SW-1:0]  wb_set_o;
    logic [WW-1:0]  wb_way_o;
    logic [TW-1:0]  wb_tag_o;
    logic           wb_done_i;
    logic [3:0]     state_dbg_o;

    dcache_flush_unit #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_W(TW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .flush_ack_o(flush_ack_o), .busy_o(busy_o),
        .meta_req_o(meta_req_o), .meta_we_o(meta_we_o), .meta_addr_o(meta_addr_o),
        .meta_gnt_i(meta_gnt_i), .meta_valid_i(meta_valid_i),
        .meta_dirty_i(meta_dirty_i), .meta_tag_i(meta_tag_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_set_o(wb_set_o),
        .wb_way_o(wb_way_o), .wb_tag_o(wb_tag_o), .wb_done_i(wb_done_i),
        .state_dbg_o(state_dbg_o)
    );

    // Clock.
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    // Behavioural metadata array.
    logic [NW-1:0] m_valid [NS];
    logic [NW-1:0] m_dirty [NS];
    logic [TW-1:0] m_tag   [NS][NW];

    // Scoreboard: expected writebacks {set, way, tag} and meta ops {we, set}.
    logic [EW-1:0] exp_q[$];
    logic [SW:0]   op_q[$];

    bit          rd_pending;
    int          rd_set;
    bit          last_denied;
    logic [SW:0] denied_op;
    int          deny_set, deny_left, denials;
    bit          rand_gnt;
    int          fixed_r, fixed_d;
    bit          in_req, outstanding;
    int          wait_cnt, r_target, done_cnt, extra;
    logic [EW-1:0] req_cap;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic build_exp();
        op_q.delete();
        exp_q.delete();
        for (int s = 0; s < NS; s++) begin
            op_q.push_back({1'b0, SW'(s)});
            for (int w = 0; w < NW; w++)
                if (m_valid[s][w] && m_dirty[s][w])
                    exp_q.push_back({SW'(s), WW'(w), m_tag[s][w]});
            op_q.push_back({1'b1, SW'(s)});
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < NS; s++) begin
            m_valid[s] = '0;
            m_dirty[s] = '0;
            for (int w = 0; w < NW; w++) m_tag[s][w] = TW'($urandom);
        end
    endtask

    task automatic randomize_model();
        for (int s = 0; s < NS; s++) begin
            m_valid[s] = NW'($urandom);
            m_dirty[s] = NW'($urandom);
            for (int w = 0; w < NW; w++) m_tag[s][w] = TW'($urandom);
        end
    endtask

    // One clock: advance, then act as metadata array and writeback sink.
    task automatic step();
        logic [SW:0]   want_op;
        logic [EW-1:0] front;
        logic [EW-1:0] seen;
        bit            gnt;
        @(posedge clk_i);
        #1;
        cyc++;
        // Read data: valid only the cycle after a granted read, noise otherwise.
        if (rd_pending) begin
            meta_valid_i = m_valid[rd_set];
            meta_dirty_i = m_dirty[rd_set];
            for (int w = 0; w < NW; w++) meta_tag_i[w*TW +: TW] = m_tag[rd_set][w];
            rd_pending = 0;
        end else begin
            meta_valid_i = NW'($urandom);
            meta_dirty_i = NW'($urandom);
            meta_tag_i   = MTW'($urandom);
        end
        // Metadata array grant.
        if (meta_req_o) begin
            if (last_denied) check_eq("meta_hold", {meta_we_o, meta_addr_o}, denied_op);
            if (!meta_we_o && int'(meta_addr_o) == deny_set && deny_left > 0) begin
                gnt = 0;
                deny_left--;
            end else if (rand_gnt) gnt = ($urandom_range(0, 2) != 0);
            else gnt = 1;
            meta_gnt_i = gnt;
            if (!gnt) begin
                denials++;
                last_denied = 1;
                denied_op = {meta_we_o, meta_addr_o};
            end else begin
                last_denied = 0;
                check_eq("meta_op_avail", op_q.size() != 0, 1);
                if (op_q.size() != 0) begin
                    want_op = op_q.pop_front();
                    check_eq("meta_op", {meta_we_o, meta_addr_o}, want_op);
                end
                if (!meta_we_o) begin
                    rd_pending = 1;
                    rd_set = int'(meta_addr_o);
                end else begin
                    check_eq("inv_wb_idle", {in_req, outstanding}, 0);
                    front = (exp_q.size() != 0) ? exp_q[0] : '1;
                    check_eq("inv_after_wbs", (exp_q.size() != 0) && (front[EW-1 -: SW] == meta_addr_o), 0);
                    m_valid[meta_addr_o] = '0;
                    m_dirty[meta_addr_o] = '0;
                end
            end
        end else begin
            meta_gnt_i = 1'($urandom_range(0, 1));
            last_denied = 0;
        end
        // Writeback sink.
        seen = {wb_set_o, wb_way_o, wb_tag_o};
        if (outstanding) begin
            check_eq("wb_single", wb_valid_o, 0);
            wb_ready_i = 1'($urandom_range(0, 1));
            done_cnt--;
            wb_done_i = (done_cnt == 0);
            if (done_cnt == 0) outstanding = 0;
        end else if (wb_valid_o) begin
            if (!in_req) begin
                in_req = 1;
                req_cap = seen;
                wait_cnt = 0;
                r_target = (fixed_r >= 0) ? fixed_r : $urandom_range(0, 3);
            end else begin
                check_eq("wb_stable", seen, req_cap);
            end
            wb_done_i = 1'($urandom_range(0, 1));
            if (wait_cnt == r_target) begin
                wb_ready_i = 1;
                in_req = 0;
                check_eq("wb_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    front = exp_q.pop_front();
                    check_eq("wb_line", seen, front);
                end
                outstanding = 1;
                done_cnt = (fixed_d >= 1) ? fixed_d : $urandom_range(1, 4);
                extra += r_target + done_cnt + 2;
            end else begin
                wb_ready_i = 0;
                wait_cnt++;
            end
        end else begin
            wb_ready_i = 1'($urandom_range(0, 1));
            wb_done_i  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_all_idle_outputs(input string tag);
        check_eq({tag, "_ack"},   flush_ack_o, 0);
        check_eq({tag, "_busy"},  busy_o, 0);
        check_eq({tag, "_req"},   meta_req_o, 0);
        check_eq({tag, "_we"},    meta_we_o, 0);
        check_eq({tag, "_wbv"},   wb_valid_o, 0);
        check_eq({tag, "_addr"},  meta_addr_o, 0);
        check_eq({tag, "_wbset"}, wb_set_o, 0);
        check_eq({tag, "_way"},   wb_way_o, 0);
        check_eq({tag, "_tag"},   wb_tag_o, 0);
        check_eq({tag, "_state"}, state_dbg_o, 0);
    endtask

    // Full flush from IDLE, with flush_i held 3 cycles past the ack.
    task automatic run_flush(input int budget);
        bit got_ack;
        int vcount;
        build_exp();
        denials = 0;
        extra = 0;
        got_ack = 0;
        flush_i = 1;
        cyc = 0;
        while (!got_ack && cyc < budget) begin
            step();
            check_eq("busy_in_flush", busy_o, 1);
            if (flush_ack_o) begin
                got_ack = 1;
                check_eq("ack_cycle", cyc, 4 * NS + 1 + denials + extra);
            end
        end
        check_eq("ack_seen", got_ack, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("ack_single", flush_ack_o, 0);
            check_eq("busy_after_ack", busy_o, 0);
            check_eq("no_rewalk", meta_req_o, 0);
        end
        flush_i = 0;
        step();
        check_eq("idle_after_low", state_dbg_o, 0);
        check_eq("ops_left", op_q.size(), 0);
        check_eq("wbs_left", exp_q.size(), 0);
        vcount = 0;
        for (int s = 0; s < NS; s++) vcount += $countones(m_valid[s]);
        check_eq("all_invalid", vcount, 0);
    endtask

    // Stimulus and final report.
    initial begin
        rst_i = 1; flush_i = 0; meta_gnt_i = 0;
        meta_valid_i = '0; meta_dirty_i = '0; meta_tag_i = '0;
        wb_ready_i = 0; wb_done_i = 0;
        rd_pending = 0; last_denied = 0; in_req = 0; outstanding = 0;
        deny_set = -1; deny_left = 0; rand_gnt = 0; fixed_r = -1; fixed_d = -1;
        cyc = 0;
        clear_model();
        repeat (3) step();
        check_all_idle_outputs("reset");
        rst_i = 0;
        step();

        // Clean cache, grant always high: ack in cycle 17.
        run_flush(200);

        // Two dirty lines in set 2, a dirty-but-invalid way, a clean-valid way.
        clear_model();
        m_valid[2] = 2'b11; m_dirty[2] = 2'b11;
        m_tag[2][0] = 12'h03C; m_tag[2][1] = 12'h0A5;
        m_valid[1] = 2'b00; m_dirty[1] = 2'b01;
        m_valid[3] = 2'b10; m_dirty[3] = 2'b00;
        fixed_r = 0; fixed_d = 1;
        run_flush(200);

        // Writeback backpressure: ready after 5 stalls, done 7 cycles later.
        clear_model();
        m_valid[0] = 2'b10; m_dirty[0] = 2'b10;
        m_valid[3] = 2'b01; m_dirty[3] = 2'b01;
        fixed_r = 5; fixed_d = 7;
        run_flush(300);

        // Grant denied 3 times on the read of set 1.
        clear_model();
        fixed_r = -1; fixed_d = -1;
        deny_set = 1; deny_left = 3;
        run_flush(200);
        deny_set = -1;

        // Second complete walk after rearm.
        run_flush(200);

        // Randomized contents, grants and writeback latencies.
        rand_gnt = 1;
        for (int it = 0; it < 6; it++) begin
            randomize_model();
            run_flush(1000);
        end
        rand_gnt = 0;

        // Reset while a writeback request is pending.
        clear_model();
        m_valid[1] = 2'b01; m_dirty[1] = 2'b01;
        m_valid[3] = 2'b11; m_dirty[3] = 2'b10;
        fixed_r = 1000;
        build_exp();
        flush_i = 1;
        cyc = 0;
        while (!wb_valid_o && cyc < 200) step();
        check_eq("rst_reached_wb", wb_valid_o, 1);
        rst_i = 1;
        #1;
        check_all_idle_outputs("rst_mid");
        flush_i = 0;
        in_req = 0; outstanding = 0; rd_pending = 0; last_denied = 0;
        op_q.delete(); exp_q.delete();
        step();
        check_eq("rst_hold_ack", flush_ack_o, 0);
        rst_i = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("post_rst_ack", flush_ack_o, 0);
            check_eq("post_rst_busy", busy_o, 0);
        end
        fixed_r = -1;
        run_flush(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_flush_unit.md
# dcache_flush_unit

Responder side of the data-cache flush handshake. It accepts the level flush request from the flush controller, walks every set of the write-back data cache, and writes back each valid dirty line. It then invalidates every way of every set and returns a single-cycle acknowledge. It sits inside the write-back dcache, between the controller's flush request and the cache's metadata array and writeback (eviction) path.

## Interface
- NUM_SETS, default 256: number of cache sets; power of two, ≥2.
- NUM_WAYS, default 8: ways per set, ≥1.
- TAG_W, default 44: tag width.
- SET_W, default $clog2(NUM_SETS): set-index width (derived).

Ports (name, direction, width, meaning):
- clk_i, in, 1: clock.
- rst_i, in, 1: asynchronous, active-high reset.
- flush_i, in, 1: level flush request; held high until acknowledged.
- flush_ack_o, out, 1: one-cycle pulse when the flush completes.
- busy_o, out, 1: high from request acceptance until the acknowledge cycle inclusive; stalls the other cache ports.
- meta_req_o, out, 1: metadata array access request.
- meta_we_o, out, 1: metadata write (1) or read (0).
- meta_addr_o, out, SET_W: set index.
- meta_gnt_i, in, 1: array grant for this cycle's request.
- meta_valid_i, in, NUM_WAYS: per-way valid bits; read data, valid one cycle after the granted read.
- meta_dirty_i, in, NUM_WAYS: per-way dirty bits; same timing as meta_valid_i.
- meta_tag_i, in, NUM_WAYS*TAG_W: per-way tags, way w at [w*TAG_W +: TAG_W]; same timing.
- wb_valid_o, out, 1: writeback request.
- wb_ready_i, in, 1: writeback request accepted.
- wb_set_o, out, SET_W: set of the line to write back.
- wb_way_o, out, $clog2(NUM_WAYS) (min 1): way of the line to write back.
- wb_tag_o, out, TAG_W: tag of the line to write back.
- wb_done_i, in, 1: pulse when the accepted writeback has reached memory.

## Operation
- States: IDLE, READ, CAPTURE, CHECK, WB_REQ, WB_WAIT, INV, DONE, WAIT_LOW.
- IDLE: when flush_i=1, clear set_cnt to 0 and go to READ.
- READ: drive meta_req_o=1, meta_we_o=0, meta_addr_o=set_cnt. Hold until meta_gnt_i, then go to CAPTURE.
- CAPTURE: register pend = meta_valid_i & meta_dirty_i and register all tags. Go to CHECK.
- CHECK: if pend≠0, select the lowest set bit w, clear pend[w], latch way/tag, and go to WB_REQ. Otherwise go to INV.
- WB_REQ: hold wb_valid_o=1 with stable set/way/tag until wb_ready_i. Then go to WB_WAIT.
- WB_WAIT: wait for wb_done_i, then go to CHECK. Only one writeback is outstanding at a time.
- INV: drive meta_req_o=1, meta_we_o=1, meta_addr_o=set_cnt. The array clears valid and dirty of all ways. Hold until meta_gnt_i.
  - Then, if set_cnt==NUM_SETS-1, go to DONE.
  - Otherwise increment set_cnt and go to READ.
- DONE: flush_ack_o=1 for exactly this cycle, then go to WAIT_LOW.
- WAIT_LOW: busy_o=0. Return to IDLE once flush_i=0. A still-high flush_i after the ack never starts a second flush.
- The set counter is SET_W bits and never wraps during a flush; the terminal test is on NUM_SETS-1.
- wb_done_i or wb_ready_i outside WB_WAIT/WB_REQ is ignored.
- Clean-valid and invalid lines are never written back.

## Timing
- Reset values: state=IDLE, set_cnt=0, pend=0.
- Outputs during reset: flush_ack_o=0, busy_o=0, meta_req_o=0, meta_we_o=0, wb_valid_o=0. Address, way and tag outputs are 0.
- Reset mid-flush returns to IDLE immediately. No ack is issued, and no writeback request remains asserted after reset.
- flush_i is sampled at the clock edge in IDLE. busy_o rises the next cycle (first READ cycle).
- Fully clean cache with meta_gnt_i tied to 1:
  - each set takes 4 cycles (READ, CAPTURE, CHECK, INV);
  - with flush_i sampled at edge 0, flush_ack_o is high in cycle 4*NUM_SETS+1.
- Each dirty line adds 1 + (cycles waiting for wb_ready_i) + (cycles waiting for wb_done_i) + 1 CHECK cycle.
- A denied grant (meta_gnt_i=0) stretches READ/INV one cycle per denial, with request and address stable.
- meta_* outputs are registered-state decodes; no combinational path from any input to any output except the meta_req_o hold, which depends on state only.

## Test plan
- Clean cache: NUM_SETS=4, NUM_WAYS=2, grant tied high, no dirty bits.
  - Raise flush_i at edge 0.
  - Required: 4 reads then 4 invalidate writes to sets 0..3, zero wb_valid_o, ack in cycle 17, busy_o high cycles 1–17.
- Dirty lines: set 2 way 1 and set 2 way 0 both valid+dirty, tags 0xA5 and 0x3C.
  - Required: writebacks in order way 0 (tag 0x3C) then way 1 (tag 0xA5), both with wb_set_o=2.
  - Required: the INV of set 2 only after the second wb_done_i.
  - Required: a dirty-but-invalid way produces no writeback.
- Backpressure: wb_ready_i low for 5 cycles, wb_done_i 7 cycles later.
  - Required: wb_valid_o and set/way/tag stable throughout the stall, and no second request before wb_done_i.
- Grant denial: meta_gnt_i low for 3 cycles on READ of set 1.
  - Required: meta_addr_o=1 held, and completion delayed by exactly 3 cycles.
- Rearm: keep flush_i high 3 cycles after the ack.
  - Required: a single ack and no new READ.
  - Lower then raise flush_i: a second complete walk.
- Reset mid-flush: assert rst_i during WB_REQ.
  - Required: all outputs 0 at once, state IDLE, no ack.
  - A new flush_i afterwards starts from set 0.
